mpu_cmd_buff: RTL and testbench

MPU_CMD_BUFF -- requirements
Module: mpu_cmd_buff

---
 rtl/mpu_cmd_buff_pkg.sv | 29 ++
 rtl/mpu_wr_strobe.sv | 23 ++
 rtl/mpu_cmd_buff.sv | 131 +++++++++++++
 tb/tb_mpu_cmd_buff.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_cmd_buff_pkg.sv
// Shared definitions for the MPU command buffer: FSM encoding, header word
// indices and the derived widths at the default configuration.
package mpu_cmd_buff_pkg;

  typedef enum logic [1:0] {
    HDR_CNT  = 2'd0,
    HDR_MASK = 2'd1,
    PAYLOAD  = 2'd2
  } state_t;

  localparam int unsigned HDR_CNT_IDX  = 0;
  localparam int unsigned HDR_MASK_IDX = 1;

  localparam int unsigned DEF_NUM_TAGS      = 10;
  localparam int unsigned DEF_NUM_CHANNELS  = 4;
  localparam int unsigned DEF_CHANNEL_WIDTH = 64;
  localparam int unsigned DEF_WRITE_WIDTH   = 16;

  // Counter width that stays legal for a single-word beat.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DATA_WIDTH = DEF_NUM_CHANNELS * DEF_CHANNEL_WIDTH;
  localparam int unsigned WPB        = DATA_WIDTH / DEF_WRITE_WIDTH;
  localparam int unsigned WCNT_W     = cnt_width(WPB);
  localparam int unsigned BCNT_W     = DEF_WRITE_WIDTH;

endpackage

// File: rtl/mpu_wr_strobe.sv
// Rising-edge detector on the microcontroller write strobe: a held-high
// wr_ena yields a single-cycle wr_pulse.
module mpu_wr_strobe (
  input  logic clk,
  input  logic rst,
  input  logic wr_ena,
  output logic wr_pulse
);

  logic wr_ena_q;

  // Remember last cycle's strobe level.
  always_ff @(posedge clk) begin
    if (rst) wr_ena_q <= 1'b0;
    else     wr_ena_q <= wr_ena;
  end

  // Pulse in the first cycle the strobe is seen high.
  always_comb begin
    wr_pulse = wr_ena & ~wr_ena_q;
  end

endmodule

// File: rtl/mpu_cmd_buff.sv
// Collects microcontroller words into framed AXI-Stream beats:
// word 0 = beat count, word 1 = tag mask, then count*WPB payload words.
module mpu_cmd_buff
  import mpu_cmd_buff_pkg::*;
#(
  parameter int unsigned NUM_TAGS      = DEF_NUM_TAGS,
  parameter int unsigned NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int unsigned CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
  parameter int unsigned WRITE_WIDTH   = DEF_WRITE_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_ena,
  input  logic [WRITE_WIDTH-1:0]                  wr_data,
  output logic                                    wr_ready,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_TAGS-1:0]                     m_axis_tuser,
  output logic                                    m_axis_tlast,
  output logic                                    wr_err
);

  localparam int unsigned DW    = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int unsigned WORDS = DW / WRITE_WIDTH;
  localparam int unsigned WC_W  = cnt_width(WORDS);

  localparam logic [WC_W-1:0]        WORD_LAST = WC_W'(WORDS - 1);
  localparam logic [WC_W-1:0]        WORD_ONE  = WC_W'(1);
  localparam logic [WRITE_WIDTH-1:0] BEAT_ONE  = WRITE_WIDTH'(1);

  if (NUM_TAGS > WRITE_WIDTH || (DW % WRITE_WIDTH) != 0) begin : g_bad_cfg
    $error("mpu_cmd_buff: NUM_TAGS must fit a write word and the beat must be whole words");
  end

  state_t                  state;
  logic [WC_W-1:0]         word_cnt;
  logic [WRITE_WIDTH-1:0]  beat_cnt;
  logic [WRITE_WIDTH-1:0]  beat_total;
  logic [NUM_TAGS-1:0]     frame_mask;
  logic [DW-1:0]           acc;
  logic [DW-1:0]           acc_next;
  logic                    wr_pulse;
  logic                    wr_acc;
  logic                    wr_drop;
  logic                    beat_done;
  logic                    last_beat;

  mpu_wr_strobe u_wr_strobe (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_pulse (wr_pulse)
  );

  // Backpressure only when the completing word would overwrite a beat that is
  // not being taken this cycle; a same-cycle handshake keeps writes flowing.
  always_comb begin
    wr_ready  = !((state == PAYLOAD) && (word_cnt == WORD_LAST) &&
                  m_axis_tvalid && !m_axis_tready);
    wr_acc    = wr_pulse & wr_ready;
    wr_drop   = wr_pulse & ~wr_ready;
    beat_done = (word_cnt == WORD_LAST);
    last_beat = ((beat_cnt + BEAT_ONE) == beat_total);
  end

  // Accumulator with the incoming word merged at its little-endian slot, so
  // the completing word goes straight into the output register.
  always_comb begin
    acc_next = acc;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (word_cnt == WC_W'(k)) acc_next[k*WRITE_WIDTH +: WRITE_WIDTH] = wr_data;
    end
  end

  // Frame FSM, counters, accumulator, output register and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HDR_CNT;
      word_cnt      <= '0;
      beat_cnt      <= '0;
      beat_total    <= '0;
      frame_mask    <= '0;
      acc           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      wr_err        <= 1'b0;
    end else begin
      if (wr_drop) wr_err <= 1'b1;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (wr_acc) begin
        unique case (state)
          HDR_CNT: begin
            if (wr_data != '0) begin
              beat_total <= wr_data;
              state      <= HDR_MASK;
            end
          end
          HDR_MASK: begin
            frame_mask <= wr_data[NUM_TAGS-1:0];
            word_cnt   <= '0;
            beat_cnt   <= '0;
            state      <= PAYLOAD;
          end
          PAYLOAD: begin
            acc <= acc_next;
            if (beat_done) begin
              word_cnt      <= '0;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= acc_next;
              m_axis_tuser  <= frame_mask;
              m_axis_tlast  <= last_beat;
              if (last_beat) begin
                beat_cnt <= '0;
                state    <= HDR_CNT;
              end else begin
                beat_cnt <= beat_cnt + BEAT_ONE;
              end
            end else begin
              word_cnt <= word_cnt + WORD_ONE;
            end
          end
          default: state <= HDR_CNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu_cmd_buff.sv
// Scoreboard bench for mpu_cmd_buff at default parameters.
module tb_mpu_cmd_buff;
  import mpu_cmd_buff_pkg::*;

  localparam int unsigned DW  = 256;
  localparam int unsigned WW  = 16;
  localparam int unsigned NT  = 10;
  localparam int unsigned NWB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_ena;
  logic [WW-1:0] wr_data;
  logic          wr_ready;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [NT-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          wr_err;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NT-1:0] user;
    logic          tlast;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mon_e;
  logic [DW-1:0] model_beat = '0;
  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  int unsigned   n_hs     = 0;
  bit            gap_win  = 0;
  bit            gap_seen = 0;

  mpu_cmd_buff #(
    .NUM_TAGS      (NT),
    .NUM_CHANNELS  (4),
    .CHANNEL_WIDTH (64),
    .WRITE_WIDTH   (WW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_ena        (wr_ena),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .wr_err        (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Handshakes are sampled on the falling edge; tready only changes after rising edges.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", DW'(exp_q.size()), DW'(1));
      end else begin
        mon_e = exp_q.pop_front();
        chk("tdata", m_axis_tdata, mon_e.data);
        chk("tuser", DW'(m_axis_tuser), DW'(mon_e.user));
        chk("tlast", DW'(m_axis_tlast), DW'(mon_e.tlast));
        n_hs++;
      end
    end
    if (gap_win && !m_axis_tvalid) gap_seen = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [WW-1:0] d, input bit rdy_pulse = 1'b0);
    wr_ena  = 1'b1;
    wr_data = d;
    if (rdy_pulse) m_axis_tready = 1'b1;
    tick();
    wr_ena = 1'b0;
    if (rdy_pulse) m_axis_tready = 1'b0;
    tick();
  endtask

  task automatic pay(input int unsigned k, input logic [WW-1:0] d, input logic [NT-1:0] mask,
                     input bit last, input bit rdy_pulse = 1'b0);
    model_beat[k*WW +: WW] = d;
    if (k == NWB - 1) exp_q.push_back('{data: model_beat, user: mask, tlast: last});
    wr(d, rdy_pulse);
  endtask

  task automatic send_beat(input logic [WW-1:0] base, input logic [NT-1:0] mask, input bit last);
    for (int unsigned k = 0; k < NWB; k++) pay(k, base + WW'(k), mask, last);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk(tag, DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_ena = 1'b0; wr_data = '0; m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_tlast",  DW'(m_axis_tlast),  DW'(0));
    chk("rst_tdata",  m_axis_tdata,       DW'(0));
    chk("rst_tuser",  DW'(m_axis_tuser),  DW'(0));
    chk("rst_wr_err", DW'(wr_err),        DW'(0));
    chk("rst_wr_rdy", DW'(wr_ready),      DW'(1));
    rst = 1'b0;
    tick();

    // Two-beat frame, free-flowing output.
    m_axis_tready = 1'b1;
    wr(16'd2);
    wr(16'h0005);
    send_beat(16'h0000, 10'h005, 1'b0);
    send_beat(16'h0010, 10'h005, 1'b1);
    drain("s1_drain");
    chk("s1_beats", DW'(n_hs), DW'(2));
    chk("s1_state", DW'(dut.state), DW'(HDR_CNT));

    // Held-high strobe gives one write.
    wr_ena = 1'b1; wr_data = 16'd1;
    repeat (5) tick();
    wr_ena = 1'b0;
    tick();
    chk("s2_state", DW'(dut.state), DW'(HDR_MASK));
    wr(16'h00C3);
    send_beat(16'h1000, 10'h0C3, 1'b1);
    drain("s2_drain");
    chk("s2_beats", DW'(n_hs), DW'(3));

    // Zero count ignored; upper mask bits dropped.
    wr(16'd0);
    repeat (3) tick();
    chk("s3_state", DW'(dut.state), DW'(HDR_CNT));
    chk("s3_nobeat", DW'(n_hs), DW'(3));
    wr(16'd1);
    wr(16'hFFFF);
    send_beat(16'h2000, 10'h3FF, 1'b1);
    drain("s3_drain");
    chk("s3_beats", DW'(n_hs), DW'(4));

    // Backpressure: dropped write sets wr_err and is not stored.
    m_axis_tready = 1'b0;
    wr(16'd2);
    wr(16'h000A);
    send_beat(16'h3000, 10'h00A, 1'b0);
    chk("s4_pending", DW'(m_axis_tvalid), DW'(1));
    for (int unsigned k = 0; k < 14; k++) pay(k, 16'h3010 + WW'(k), 10'h00A, 1'b1);
    chk("s4_rdy_hi", DW'(wr_ready), DW'(1));
    pay(14, 16'h301E, 10'h00A, 1'b1);
    chk("s4_rdy_lo", DW'(wr_ready), DW'(0));
    wr(16'hDEAD);
    chk("s4_err", DW'(wr_err), DW'(1));
    chk("s4_hold", m_axis_tdata, exp_q[0].data);
    m_axis_tready = 1'b1;
    tick();
    chk("s4_rdy_back", DW'(wr_ready), DW'(1));
    pay(15, 16'h301F, 10'h00A, 1'b1);
    drain("s4_drain");
    chk("s4_beats", DW'(n_hs), DW'(6));
    chk("s4_err_sticky", DW'(wr_err), DW'(1));

    // tready coincident with the completing write: no tvalid bubble.
    m_axis_tready = 1'b0;
    wr(16'd3);
    wr(16'h0155);
    send_beat(16'h4000, 10'h155, 1'b0);
    gap_seen = 0;
    gap_win  = 1;
    for (int unsigned k = 0; k < 15; k++) pay(k, 16'h4010 + WW'(k), 10'h155, 1'b0);
    pay(15, 16'h401F, 10'h155, 1'b0, 1'b1);
    chk("s5_tvalid", DW'(m_axis_tvalid), DW'(1));
    chk("s5_tdata2", m_axis_tdata, exp_q[0].data);
    for (int unsigned k = 0; k < 15; k++) pay(k, 16'h4020 + WW'(k), 10'h155, 1'b1);
    pay(15, 16'h402F, 10'h155, 1'b1, 1'b1);
    gap_win = 0;
    chk("s5_nogap", DW'(gap_seen), DW'(0));
    m_axis_tready = 1'b1;
    drain("s5_drain");
    chk("s5_beats", DW'(n_hs), DW'(9));

    // Reset mid-frame discards the partial beat.
    wr(16'd1);
    wr(16'h0002);
    for (int unsigned k = 0; k < 7; k++) wr(16'h6000 + WW'(k));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("s6_err", DW'(wr_err), DW'(0));
    chk("s6_wcnt", DW'(dut.word_cnt), DW'(0));
    chk("s6_bcnt", DW'(dut.beat_cnt), DW'(0));
    chk("s6_state", DW'(dut.state), DW'(HDR_CNT));
    repeat (3) tick();
    chk("s6_nobeat", DW'(n_hs), DW'(9));
    wr(16'd1);
    wr(16'h0201);
    send_beat(16'h5000, 10'h201, 1'b1);
    drain("s6_drain");
    chk("s6_beats", DW'(n_hs), DW'(10));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
